// File: rtl/fifo_uart_pkg.sv
// Shared types and line levels for the FIFO-fed UART transmitter.
// The optional parity bit is enabled with the FIFO_TX_PARITY_EN macro.
package fifo_uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } tx_state_t;

   localparam logic TX_IDLE_LVL = 1'b1;
   localparam logic START_LVL   = 1'b0;
   localparam logic STOP_LVL    = 1'b1;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Loadable bit-period down-counter; bit_done flags the last cycle of each serial bit.
// A divisor of zero is treated as one cycle per bit.
module uart_tx_bit_timer #(
   parameter int unsigned DIV_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 run,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 bit_done
);

   logic [DIV_WIDTH-1:0] period_q, period_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] reload_val;

   assign reload_val = (div == '0) ? '0 : div - DIV_WIDTH'(1);
   assign bit_done   = (cnt_q == '0);

   always_comb begin
      period_d = period_q;
      cnt_d    = cnt_q;
      if (load) begin
         period_d = reload_val;
         cnt_d    = reload_val;
      end else if (run) begin
         cnt_d = (cnt_q == '0) ? period_q : cnt_q - DIV_WIDTH'(1);
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_q <= '0;
         cnt_q    <= '0;
      end else begin
         period_q <= period_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains an async FIFO and sends each word as a start/data/[parity]/stop serial frame.
// Define FIFO_TX_PARITY_EN to insert a parity bit between data and stop.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DIV_WIDTH  = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  FIFO_EMPTY,
   input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
   output logic                  FIFO_R_INC,
   input  logic                  TX_EN,
   input  logic [DIV_WIDTH-1:0]  CLK_DIV,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  BUSY
);

   localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   tx_state_t             state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic                  tx_q, tx_d;
   logic                  busy_q;
   logic                  par_bit;
   logic                  bit_done;
   logic                  pop;

   uart_tx_bit_timer #(
      .DIV_WIDTH(DIV_WIDTH)
   ) u_bit_timer (
      .clk     (CLK),
      .rst     (RST),
      .load    (pop),
      .run     (state_q != StIdle),
      .div     (CLK_DIV),
      .bit_done(bit_done)
   );

`ifdef FIFO_TX_PARITY_EN
   logic par_q, par_d;

   assign par_bit = par_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) par_q <= 1'b0;
      else     par_q <= par_d;
   end

   always_comb begin
      par_d = par_q;
      if (pop) par_d = ^FIFO_RD_DATA ^ PAR_TYP;
   end
`else
   logic unused_par_typ;

   assign unused_par_typ = PAR_TYP;
   assign par_bit        = 1'b0;
`endif

   // Pop is allowed from idle or on the final stop cycle, giving back-to-back frames.
   assign pop        = TX_EN & ~FIFO_EMPTY &
                       ((state_q == StIdle) | ((state_q == StStop) & bit_done));
   assign FIFO_R_INC = pop & ~RST;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      unique case (state_q)
         StStart: if (bit_done) state_d = StData;
         StData: begin
            if (bit_done) begin
               if (idx_q == IdxW'(DATA_WIDTH - 1)) begin
                  idx_d = '0;
`ifdef FIFO_TX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end else begin
                  idx_d   = idx_q + IdxW'(1);
                  shift_d = shift_q >> 1;
               end
            end
         end
         StParity: if (bit_done) state_d = StStop;
         StStop:   if (bit_done) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
      if (pop) begin
         state_d = StStart;
         shift_d = FIFO_RD_DATA;
      end
   end

   // Line level follows the next state so TX_OUT is a clean register output.
   always_comb begin
      tx_d = TX_IDLE_LVL;
      unique case (state_d)
         StStart:  tx_d = START_LVL;
         StData:   tx_d = shift_d[0];
         StParity: tx_d = par_bit;
         StStop:   tx_d = STOP_LVL;
         default:  tx_d = TX_IDLE_LVL;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
         shift_q <= '0;
         idx_q   <= '0;
         tx_q    <= TX_IDLE_LVL;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
         busy_q  <= (state_d != StIdle);
      end
   end

   assign TX_OUT = tx_q;
   assign BUSY   = busy_q;

endmodule
